alu32_cmd_seq: RTL

Command sequencer that drives the registered 32-bit ALU (`sel` 0000 AND, 0001 OR, 0010 NOT a, 0011 XOR; result registered on `clk`). It accepts one operation at a time over a valid/ready command channel, presents operands and `sel` to the ALU, and waits out the ALU latency. It then returns the captured result over a valid/ready response channel. Illegal opcodes are rejected without touching the ALU. The block sits between bus/control logic and the ALU datapath.

---
 rtl/alu32_cmd_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/alu32_cmd_seq.sv
// alu32_cmd_seq
// Command sequencer in front of a registered 32-bit ALU
// (sel 0000 AND, 0001 OR, 0010 NOT a, 0011 XOR).
//
// Operation:
//   - Accepts one operation at a time on a valid/ready command channel.
//   - Drives registered operands/opcode to the ALU.
//   - Waits out the ALU latency, then returns the captured result on a
//     valid/ready response channel.
//   - Illegal opcodes (sel >= 0100) are answered immediately with rsp_err=1
//     and rsp_data=0, without touching the ALU operand registers.
//
// Optional feature macro: ALU_SEQ_CHAIN_EN
//   When defined, a chain register keeps the last legal result. A command
//   with cmd_chain=1 then takes alu_b from that register instead of cmd_b.
//   When undefined, cmd_chain is ignored.
//
// Parameters:
//   WIDTH : operand/result width (32)
//   LAT   : ALU latency in cycles from operands presented to alu_out valid (1..4)
//
// Ports:
//   clk, rst_n                : clock, synchronous active-low reset
//   cmd_valid/cmd_ready       : command handshake
//   cmd_sel, cmd_a, cmd_b     : opcode and operands
//   cmd_chain                 : use previous result as operand b (macro only)
//   rsp_valid/rsp_ready       : response handshake
//   rsp_data, rsp_err         : result (0 on error), illegal-opcode flag
//   alu_a, alu_b, alu_sel     : registered operands/opcode to the ALU
//   alu_out                   : ALU result
//   op_cnt                    : count of completed legal operations (wraps)
module alu32_cmd_seq #(
    parameter int WIDTH = 32,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_sel,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_chain,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic [15:0]      op_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // EXEC lasts LAT+1 cycles:
    //   - one cycle for the operand registers to reach the ALU,
    //   - LAT cycles for the ALU itself.
    // The counter starts at 0, so completion happens when it reads LAT.
    localparam logic [2:0] LAT_LAST = 3'(LAT);

    state_t           state;
    logic [2:0]       lat_cnt;
    logic             legal;
    logic             done;
    logic [WIDTH-1:0] b_next;

    assign legal     = (cmd_sel[3:2] == 2'b00);
    assign done      = (state == EXEC) && (lat_cnt == LAT_LAST);
    assign cmd_ready = (state == IDLE);

`ifdef ALU_SEQ_CHAIN_EN
    logic [WIDTH-1:0] chain_q;

    assign b_next = cmd_chain ? chain_q : cmd_b;

    // Only legal completions update the chain register; error responses do not.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else if (done) begin
            chain_q <= alu_out;
        end
    end
`else
    logic unused_chain;

    assign unused_chain = cmd_chain;
    assign b_next       = cmd_b;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= 4'b0000;
            op_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (legal) begin
                            alu_a   <= cmd_a;
                            alu_b   <= b_next;
                            alu_sel <= cmd_sel;
                            lat_cnt <= '0;
                            state   <= EXEC;
                        end else begin
                            // Rejected without disturbing the ALU operand registers.
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                EXEC: begin
                    if (done) begin
                        rsp_data  <= alu_out;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        op_cnt    <= op_cnt + 16'd1;
                        state     <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
